// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths and state encoding for the MEM-stage access controller.
package mem_access_ctrl_pkg;

   localparam int RegAddrWidth = 5;
   localparam int RegDataWidth = 32;
   localparam int MacCntWidth  = 8;

   typedef enum logic [1:0] {
      MAC_IDLE = 2'd0,
      MAC_REQ  = 2'd1,
      MAC_DONE = 2'd2
   } mac_state_e;

endpackage

// File: rtl/mac_timeout_cnt.sv
// Wait-cycle counter for the bus handshake: synchronous clear, count enable,
// and a terminal-count flag compared against a loadable limit.
module mac_timeout_cnt
   import mem_access_ctrl_pkg::*;
#(
   parameter int W = MacCntWidth
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] tc_val,
   output logic         tc
);

   logic [W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   // tc reflects the current count, so the cycle showing tc_val is the last wait cycle.
   assign tc = (count == tc_val);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory handshake: stalls the pipeline during loads/stores,
// presents the write-back result and flags misaligned accesses and bus timeouts.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W     = RegDataWidth,
   parameter int REG_ADDR_W = RegAddrWidth,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] target_MEM,
   input  logic [DATA_W-1:0]     data_in_MEM,
   input  logic [DATA_W-1:0]     rdata_2_MEM,
   input  logic                  WriteReg_MEM,
   input  logic                  MemOrAlu_MEM,
   input  logic                  WriteMem_MEM,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  stall_req,
   output logic [REG_ADDR_W-1:0] wb_target,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  wb_we,
   output logic                  misalign,
   output logic                  bus_err
);

   mac_state_e          state;
   logic [DATA_W-1:0]   load_q;
   logic                err_q;
   logic                acc;
   logic                is_load;
   logic                aligned;
   logic                cnt_tc;

   // A store flag wins over the load flag when both are set.
   assign acc     = MemOrAlu_MEM | WriteMem_MEM;
   assign is_load = MemOrAlu_MEM & ~WriteMem_MEM;
   assign aligned = (data_in_MEM[1:0] == 2'b00);

   mac_timeout_cnt #(.W(MacCntWidth)) u_timeout_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == MAC_IDLE),
      .en     (state == MAC_REQ),
      .tc_val (MacCntWidth'(TIMEOUT - 1)),
      .tc     (cnt_tc)
   );

   // NOTE: load_q is a single datapath register, so it is reset with the control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= MAC_IDLE;
         load_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            MAC_IDLE: begin
               if (acc && aligned) begin
                  state <= MAC_REQ;
                  err_q <= 1'b0;
               end
            end
            MAC_REQ: begin
               if (mem_ack) begin
                  load_q <= mem_rdata;
                  state  <= MAC_DONE;
               end else if (cnt_tc) begin
                  err_q <= 1'b1;
                  state <= MAC_DONE;
               end
            end
            MAC_DONE: state <= MAC_IDLE;
            default:  state <= MAC_IDLE;
         endcase
      end
   end

   // Outputs are decoded from state and inputs so the pass-through and the
   // first-cycle stall are zero latency; reset masks every output at once.
   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall_req = 1'b0;
      wb_target = '0;
      wb_data   = '0;
      wb_we     = 1'b0;
      misalign  = 1'b0;
      bus_err   = 1'b0;
      if (!rst) begin
         wb_target = target_MEM;
         wb_data   = data_in_MEM;
         case (state)
            MAC_IDLE: begin
               if (!acc)
                  wb_we = WriteReg_MEM;
               else if (!aligned)
                  misalign = 1'b1;
               else
                  stall_req = 1'b1;
            end
            MAC_REQ: begin
               mem_req   = 1'b1;
               mem_we    = WriteMem_MEM;
               mem_addr  = data_in_MEM;
               mem_wdata = rdata_2_MEM;
               stall_req = 1'b1;
            end
            MAC_DONE: begin
               wb_we   = WriteReg_MEM & ~err_q;
               bus_err = err_q;
               if (is_load && !err_q)
                  wb_data = load_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and random instruction sequences for mem_access_ctrl, checked
// against a per-instruction model of the expected handshake timeline.
module tb_mem_access_ctrl;

   localparam int TMO = 4;

   typedef enum int {K_ALU, K_LOAD, K_STORE, K_BOTH} kind_e;

   logic        clk;
   logic        rst;
   logic [4:0]  target_MEM;
   logic [31:0] data_in_MEM;
   logic [31:0] rdata_2_MEM;
   logic        WriteReg_MEM;
   logic        MemOrAlu_MEM;
   logic        WriteMem_MEM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_req;
   logic [4:0]  wb_target;
   logic [31:0] wb_data;
   logic        wb_we;
   logic        misalign;
   logic        bus_err;

   int passed = 0;
   int total  = 0;

   mem_access_ctrl #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .target_MEM   (target_MEM),
      .data_in_MEM  (data_in_MEM),
      .rdata_2_MEM  (rdata_2_MEM),
      .WriteReg_MEM (WriteReg_MEM),
      .MemOrAlu_MEM (MemOrAlu_MEM),
      .WriteMem_MEM (WriteMem_MEM),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .stall_req    (stall_req),
      .wb_target    (wb_target),
      .wb_data      (wb_data),
      .wb_we        (wb_we),
      .misalign     (misalign),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input kind_e kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wr, input logic [4:0] tgt);
      target_MEM   = tgt;
      data_in_MEM  = addr;
      rdata_2_MEM  = wdata;
      WriteReg_MEM = wr;
      MemOrAlu_MEM = (kind == K_LOAD) || (kind == K_BOTH);
      WriteMem_MEM = (kind == K_STORE) || (kind == K_BOTH);
   endtask

   // Expected timeline: ALU and misaligned ops take one cycle; an aligned access
   // takes one IDLE cycle, min(ack cycle, TMO) request cycles and one DONE cycle.
   // An ack at request cycle 1..TMO completes; anything else is a timeout.
   // Entered and left at 1 time unit after a rising edge.
   task automatic run_instr(input kind_e kind, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic wr, input int ack_at);
      logic [4:0] tgt;
      logic       is_acc, is_st, is_ld, err;
      int         n;
      tgt    = 5'($urandom);
      is_acc = (kind != K_ALU);
      is_st  = (kind == K_STORE) || (kind == K_BOTH);
      is_ld  = (kind == K_LOAD);
      err    = !(ack_at >= 1 && ack_at <= TMO);
      n      = err ? TMO : ack_at;
      drive(kind, addr, wdata, wr, tgt);
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      check("wb_target", 32'(wb_target), 32'(tgt));
      check("first_mem_req", 32'(mem_req), 32'(0));
      if (!is_acc) begin
         check("alu_stall", 32'(stall_req), 32'(0));
         check("alu_wb_we", 32'(wb_we), 32'(wr));
         check("alu_wb_data", wb_data, addr);
         @(posedge clk); #1;
      end else if (addr[1:0] != 2'b00) begin
         check("mis_flag", 32'(misalign), 32'(1));
         check("mis_stall", 32'(stall_req), 32'(0));
         check("mis_wb_we", 32'(wb_we), 32'(0));
         @(posedge clk); #1;
      end else begin
         check("idle_stall", 32'(stall_req), 32'(1));
         check("idle_wb_we", 32'(wb_we), 32'(0));
         check("idle_misalign", 32'(misalign), 32'(0));
         @(posedge clk); #1;
         for (int k = 1; k <= n; k++) begin
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            check("req_mem_req", 32'(mem_req), 32'(1));
            check("req_stall", 32'(stall_req), 32'(1));
            check("req_we", 32'(mem_we), 32'(is_st));
            check("req_addr", mem_addr, addr);
            check("req_wdata", mem_wdata, wdata);
            check("req_wb_we", 32'(wb_we), 32'(0));
            check("req_bus_err", 32'(bus_err), 32'(0));
            @(posedge clk); #1;
         end
         mem_ack   = 1'($urandom);
         mem_rdata = $urandom;
         @(negedge clk);
         check("done_stall", 32'(stall_req), 32'(0));
         check("done_mem_req", 32'(mem_req), 32'(0));
         check("done_bus_err", 32'(bus_err), 32'(err));
         check("done_wb_we", 32'(wb_we), 32'(wr & ~err));
         check("done_wb_data", wb_data, (is_ld && !err) ? rdata : addr);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      drive(K_ALU, 32'h0000_0055, 32'h1, 1'b1, 5'd7);
      #3;
      check("rst_wb_we", 32'(wb_we), 32'(0));
      check("rst_wb_data", wb_data, 32'(0));
      check("rst_wb_target", 32'(wb_target), 32'(0));
      drive(K_LOAD, 32'h0000_0100, 32'h0, 1'b1, 5'd3);
      #1;
      check("rst_stall", 32'(stall_req), 32'(0));
      check("rst_mem_req", 32'(mem_req), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_instr(K_ALU,   32'h0000_0055, 32'h0,         32'h0,         1'b1, 0);
      run_instr(K_LOAD,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b1, 2);
      run_instr(K_ALU,   32'h0000_00AA, 32'h0,         32'h0,         1'b0, 0);
      run_instr(K_STORE, 32'h0000_0104, 32'h1234_5678, 32'h0,         1'b0, 1);
      run_instr(K_LOAD,  32'h0000_0102, 32'h0,         32'h0,         1'b1, 1);
      run_instr(K_LOAD,  32'h0000_0200, 32'h0,         32'hCAFE_F00D, 1'b1, 0);
      run_instr(K_LOAD,  32'h0000_0204, 32'h0,         32'hA5A5_5A5A, 1'b1, TMO);
      run_instr(K_BOTH,  32'h0000_0208, 32'h0BAD_0BAD, 32'h7777_7777, 1'b0, 3);

      // Reset while requesting: request and stall must drop before the next edge.
      drive(K_LOAD, 32'h0000_0300, 32'h0, 1'b1, 5'd9);
      mem_ack = 1'b0;
      @(posedge clk); #2;
      check("pre_rst_mem_req", 32'(mem_req), 32'(1));
      rst = 1'b1;
      #1;
      check("async_rst_mem_req", 32'(mem_req), 32'(0));
      check("async_rst_stall", 32'(stall_req), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(K_LOAD, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1'b1, 1);

      for (int i = 0; i < 40; i++) begin
         kind_e       kind;
         logic [31:0] addr;
         kind = kind_e'($urandom_range(3, 0));
         addr = $urandom;
         if ($urandom_range(3, 0) != 0) addr[1:0] = 2'b00;
         run_instr(kind, addr, $urandom, $urandom, 1'($urandom), int'($urandom_range(TMO + 1, 0)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs the data-memory load/store handshake for the instruction currently in MEM.
- Drives the stall request that feeds the EX/MEM `is_hold` input.
- Presents the write-back result (ALU data or loaded word) to the MEM/WB register.
- Flags misaligned accesses and bus timeouts.

Parameters:
- DATA_W, 32, register/memory data and byte-address width.
- REG_ADDR_W, 5, destination register index width.
- TIMEOUT, 16, maximum wait cycles for mem_ack before a bus error (range 2..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- target_MEM  in  REG_ADDR_W  destination register from EX/MEM.
- data_in_MEM  in  DATA_W  ALU result; the byte address for loads/stores.
- rdata_2_MEM  in  DATA_W  store data.
- WriteReg_MEM  in  1  instruction writes a register.
- MemOrAlu_MEM  in  1  1 = load (result comes from memory).
- WriteMem_MEM  in  1  store.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable.
- mem_addr  out  DATA_W  bus byte address.
- mem_wdata  out  DATA_W  bus write data.
- mem_ack  in  1  bus completion; read data valid on mem_rdata in the same cycle.
- mem_rdata  in  DATA_W  bus read data.
- stall_req  out  1  hold request to the upstream pipeline registers.
- wb_target  out  REG_ADDR_W  to MEM/WB.
- wb_data  out  DATA_W  to MEM/WB.
- wb_we  out  1  to MEM/WB.
- misalign  out  1  one-cycle pulse: access with addr[1:0] != 0.
- bus_err  out  1  one-cycle pulse: timeout.

Behaviour:
- Access pending: acc = MemOrAlu_MEM | WriteMem_MEM. If both inputs are set, treat it as a store.
- States:
  - IDLE
    - acc=0: no stall. wb_data = data_in_MEM, wb_we = WriteReg_MEM. Zero-latency pass-through.
    - acc=1, addr[1:0]!=0: no bus request. misalign=1 and wb_we=0 this cycle; stay in IDLE.
    - acc=1, aligned: stall_req=1 combinationally this cycle; next state REQ; wait counter cleared.
  - REQ
    - Outputs: mem_req=1, mem_we=WriteMem_MEM, mem_addr=data_in_MEM, mem_wdata=rdata_2_MEM. stall_req=1.
    - Counter increments each cycle.
    - mem_ack=1: capture mem_rdata into the load register; go to DONE.
    - Else, counter reaches TIMEOUT-1: latch the error; go to DONE.
    - ack and timeout in the same cycle: ack wins, no error.
  - DONE
    - stall_req=0, mem_req=0.
    - wb_data = captured load data for a load that completed without error; otherwise data_in_MEM.
    - wb_we = WriteReg_MEM & ~err.
    - bus_err=1 for this cycle if the error is latched.
    - Unconditionally go to IDLE. The same instruction is still presented this cycle and must not re-issue.
- Bus inputs are held stable by the stall while in REQ. mem_ack outside REQ is ignored.
- Latency:
  - ALU op: 0 extra cycles.
  - Memory op: 1 (IDLE) + N (REQ, N = ack cycle count ≥ 1) + 1 (DONE).
- Reset:
  - State IDLE, counter 0, load register 0, error flag 0.
  - While rst=1, all outputs forced to 0, including stall_req.
  - Reset during REQ drops mem_req immediately (asynchronously); the transaction is abandoned.
- Memory accesses are word only; no byte/halfword lanes.

Decomposition:
- Shared package (alongside the existing width defines):
  - State encoding constants MAC_IDLE=2'd0, MAC_REQ=2'd1, MAC_DONE=2'd2.
  - Reuse the existing RegAddrWidth / RegDataWidth defines as the parameter defaults.
- One natural sub-module: mac_timeout_cnt.
  - Loadable clear/enable counter with a terminal-count output.
  - Async active-high reset.

Test Plan:
- ALU op: WriteReg=1, data_in=0x00000055, MemOrAlu=WriteMem=0 → same cycle wb_data=0x55, wb_we=1, stall_req=0, mem_req=0.
- Load: addr 0x100; ack on 2nd REQ cycle with rdata=0xDEADBEEF.
  - stall_req high 3 cycles.
  - DONE: wb_data=0xDEADBEEF, wb_we=1.
  - Next cycle IDLE; exactly one mem_req burst.
- Store: addr 0x104, rdata_2=0x12345678, ack 1st REQ cycle.
  - mem_we=1, mem_wdata=0x12345678 during REQ.
  - DONE: wb_we=0 (WriteReg=0), stall 2 cycles.
- Misaligned: load with addr 0x102 → misalign=1 for one cycle, mem_req never asserted, wb_we=0, stall_req=0.
- Timeout: TIMEOUT=4, no ack → REQ lasts 4 cycles, then DONE with bus_err=1 and wb_we=0. Ack arriving on the 4th cycle instead → no error.
- Reset mid-REQ: assert rst asynchronously → mem_req and stall_req fall before the next clock edge. After release: IDLE, and a fresh load completes normally.
